// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e     - sequencer states
//   MemBytesDefault - default implemented memory size in bytes
//   LaneHi / LaneLo - byte-lane select within a 16-bit big-endian word
package mem_lsu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StResp
    } lsu_state_e;

    localparam int unsigned MemBytesDefault = 128;

    // Big-endian word: the byte at the word address lives in [15:8].
    localparam logic LaneHi = 1'b1;
    localparam logic LaneLo = 1'b0;

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational byte-lane formatter for the load/store unit.
// Ports:
//   word       in  16  word read from memory
//   lane       in  1   LaneHi selects [15:8], LaneLo selects [7:0]
//   sext       in  1   1 = sign-extend the selected byte, 0 = zero-extend
//   store_byte in  8   byte to merge into the selected lane
//   load_val   out 16  selected byte extended to 16 bits
//   store_word out 16  word with the selected lane replaced, other lane kept
module mem_lane_fmt
    import mem_lsu_pkg::*;
(
    input  logic [15:0] word,
    input  logic        lane,
    input  logic        sext,
    input  logic [7:0]  store_byte,
    output logic [15:0] load_val,
    output logic [15:0] store_word
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte   = word[7:0];
        store_word = word;
        if (lane == LaneHi) begin
            sel_byte   = word[15:8];
            store_word = {store_byte, word[7:0]};
        end else begin
            sel_byte   = word[7:0];
            store_word = {word[15:8], store_byte};
        end
        load_val = {{8{sext & sel_byte[7]}}, sel_byte};
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for a byte-addressed data memory with a 16-bit
// big-endian word interface and a 1-cycle registered read. One request at a
// time; byte stores are done as read-modify-write.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   req_valid / req_ready    request handshake (ready only when idle)
//   req_write                1 = store, 0 = load
//   req_byte                 1 = byte access, 0 = word access
//   req_signed               byte load: 1 = sign-extend, 0 = zero-extend
//   req_addr                 byte address
//   req_wdata                store data (byte store uses [7:0])
//   resp_valid               one-cycle response pulse
//   resp_rdata               load result; 0 for stores and errors
//   resp_err                 address out of range, qualified by resp_valid
//   mem_read / mem_write     memory strobes, never high together
//   mem_addr                 memory word address (bytes A and A+1)
//   mem_wdata                memory write data {byte A, byte A+1}
//   mem_rdata                memory read data, valid the cycle after mem_read
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_BYTES = MemBytesDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Range limits computed in address width; high address bits are never
    // masked, so anything above the limit is rejected rather than wrapped.
    localparam logic [ADDR_W-1:0] LastByte = ADDR_W'(MEM_BYTES - 1);
    localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(MEM_BYTES - 2);

    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic              byte_q, byte_d;
    logic              sext_q, sext_d;
    logic              lane_q, lane_d;
    logic              err_q, err_d;
    logic [7:0]        sbyte_q, sbyte_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;

    logic              accept;
    logic              legal;
    logic              at_top;
    logic [15:0]       fmt_load;
    logic [15:0]       fmt_store;

    assign accept = req_valid & (state_q == StIdle);
    assign legal  = req_byte ? (req_addr <= LastByte) : (req_addr <= LastWord);
    // The last byte has no successor, so it is reached as the low lane of the
    // word one below it.
    assign at_top = req_byte & (req_addr == LastByte);

    mem_lane_fmt u_lane_fmt (
        .word       (mem_rdata),
        .lane       (lane_q),
        .sext       (sext_q),
        .store_byte (sbyte_q),
        .load_val   (fmt_load),
        .store_word (fmt_store)
    );

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        byte_d   = byte_q;
        sext_d   = sext_q;
        lane_d   = lane_q;
        err_d    = err_q;
        sbyte_d  = sbyte_q;
        rdata_d  = rdata_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d = req_write;
                    byte_d  = req_byte;
                    sext_d  = req_signed;
                    sbyte_d = req_wdata[7:0];
                    lane_d  = at_top ? LaneLo : LaneHi;
                    err_d   = ~legal;
                    rdata_d = '0;
                    if (!legal) begin
                        // No strobe ever fires; mem_addr/mem_wdata keep old values.
                        state_d = StResp;
                    end else begin
                        maddr_d = at_top ? (req_addr - ADDR_W'(1)) : req_addr;
                        if (req_write && !req_byte) begin
                            mwdata_d = req_wdata;
                            state_d  = StWr;
                        end else begin
                            state_d = StRd;
                        end
                    end
                end
            end
            StRd: begin
                state_d = StCap;
            end
            StCap: begin
                if (write_q) begin
                    mwdata_d = fmt_store;
                    state_d  = StWr;
                end else begin
                    rdata_d = byte_q ? fmt_load : mem_rdata;
                    state_d = StResp;
                end
            end
            StWr: begin
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            sext_q   <= 1'b0;
            lane_q   <= LaneHi;
            err_q    <= 1'b0;
            sbyte_q  <= '0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            byte_q   <= byte_d;
            sext_q   <= sext_d;
            lane_q   <= lane_d;
            err_q    <= err_d;
            sbyte_q  <= sbyte_d;
            rdata_q  <= rdata_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;
    assign mem_read   = (state_q == StRd);
    assign mem_write  = (state_q == StWr);
    assign mem_addr   = maddr_q;
    assign mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed, table-driven bench for mem_lsu with a byte-array
// memory model (big-endian words, 1-cycle registered read).
module tb_mem_lsu;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MEM_BYTES = 128;
    localparam int          NV        = 21;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_lsu #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; image loaded on the first clock (reset is held longer).
    logic [7:0] mem [MEM_BYTES];
    bit         mem_init;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'h00;
            mem[0]   <= 8'hAB;
            mem[1]   <= 8'h99;
            mem_init <= 1'b1;
        end else if (mem_write && (int'(mem_addr) <= int'(MEM_BYTES) - 2)) begin
            mem[int'(mem_addr)]     <= mem_wdata[15:8];
            mem[int'(mem_addr) + 1] <= mem_wdata[7:0];
        end
        if (mem_read) begin
            if (int'(mem_addr) <= int'(MEM_BYTES) - 2)
                mem_rdata <= {mem[int'(mem_addr)], mem[int'(mem_addr) + 1]};
            else
                mem_rdata <= 16'h0000;
        end
    end

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (mem_read || mem_write)) check("strobe exclusive", mem_read & mem_write, 0);
    end

    typedef struct packed {
        logic        wr;
        logic        by;
        logic        sg;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        logic [15:0] maddr;
        logic [15:0] mwdata;
    } vec_t;

    vec_t tbl [NV];

    // Issue one request and follow it to its response, checking latency,
    // strobe counts, memory address/data and the response fields.
    task automatic do_req(input int idx, input vec_t v);
        int          cyc;
        int          rd;
        int          wr;
        int          lat;
        int          exp_rd;
        int          exp_wr;
        bit          got;
        logic [15:0] rd_addr;
        logic [15:0] wr_addr;
        logic [15:0] wr_data;
        string       tag;
        tag = $sformatf("v%0d", idx);
        if (v.err) begin
            lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!v.wr) begin
            lat = 3; exp_rd = 1; exp_wr = 0;
        end else if (!v.by) begin
            lat = 2; exp_rd = 0; exp_wr = 1;
        end else begin
            lat = 4; exp_rd = 1; exp_wr = 1;
        end
        @(negedge clk);
        check({tag, " ready"}, req_ready, 1);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_byte   = v.by;
        req_signed = v.sg;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; rd = 0; wr = 0; got = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_read) begin rd++; rd_addr = mem_addr; end
            if (mem_write) begin wr++; wr_addr = mem_addr; wr_data = mem_wdata; end
            if (resp_valid) begin
                got = 1'b1;
                check({tag, " rdata"}, resp_rdata, v.rdata);
                check({tag, " err"}, resp_err, v.err);
            end
        end
        check({tag, " resp seen"}, got, 1);
        check({tag, " latency"}, cyc, lat);
        check({tag, " read strobes"}, rd, exp_rd);
        check({tag, " write strobes"}, wr, exp_wr);
        if (rd > 0) check({tag, " read addr"}, rd_addr, v.maddr);
        if (wr > 0) begin
            check({tag, " write addr"}, wr_addr, v.maddr);
            check({tag, " write data"}, wr_data, v.mwdata);
        end
        @(negedge clk);
        check({tag, " single pulse"}, resp_valid, 0);
    endtask

    initial begin
        int   wr;
        int   nresp;
        vec_t v;

        n_cmp = 0; n_fail = 0;
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;

        //           wr    by    sg    addr      wdata     rdata     err   maddr     mwdata
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hAB99, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h000A, 16'h1234, 16'h0000, 1'b0, 16'h000A, 16'h1234};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h000B, 16'h0000, 16'h0034, 1'b0, 16'h000B, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h000A, 16'h0000, 16'h0012, 1'b0, 16'h000A, 16'h0000};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h000A, 16'hAAF0, 16'h0000, 1'b0, 16'h000A, 16'hF034};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h000A, 16'h0000, 16'hFFF0, 1'b0, 16'h000A, 16'h0000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0014, 16'h1234, 16'h0000, 1'b0, 16'h0014, 16'h1234};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0014, 16'h005A, 16'h0000, 1'b0, 16'h0014, 16'h5A34};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0014, 16'h0000, 16'h5A34, 1'b0, 16'h0014, 16'h0000};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h007E, 16'hBEEF, 16'h0000, 1'b0, 16'h007E, 16'hBEEF};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h007F, 16'h0077, 16'h0000, 1'b0, 16'h007E, 16'hBE77};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h007F, 16'h0000, 16'h0077, 1'b0, 16'h007E, 16'h0000};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 16'h007E, 16'h0000, 16'hFFBE, 1'b0, 16'h007E, 16'h0000};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h007F, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 16'h007F, 16'h1111, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 16'h0080, 16'h0033, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 16'h007E, 16'h0000, 16'hBE77, 1'b0, 16'h007E, 16'h0000};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 16'h0015, 16'h0000, 16'h0034, 1'b0, 16'h0015, 16'h0000};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hAB99, 1'b0, 16'h0000, 16'h0000};

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst req_ready", req_ready, 1);
        check("rst resp_valid", resp_valid, 0);
        check("rst resp_err", resp_err, 0);
        check("rst resp_rdata", resp_rdata, 0);
        check("rst mem_read", mem_read, 0);
        check("rst mem_write", mem_write, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) do_req(i, tbl[i]);

        // Handshake: valid held with shifting fields while busy. Only the
        // request present in IDLE (word load 10) may be taken after the first.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000;
        @(posedge clk);
        wr = 0; nresp = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("hs%0d ready", k), req_ready, (k == 4 || k == 8));
            check($sformatf("hs%0d resp_valid", k), resp_valid, (k == 3 || k == 7));
            if (mem_write) wr++;
            if (resp_valid) begin
                nresp++;
                check($sformatf("hs%0d rdata", k), resp_rdata, (k == 3) ? 16'hAB99 : 16'hF034);
            end
            case (k)
                1: begin req_write = 1'b1; req_byte = 1'b1; req_addr = 16'h000A; req_wdata = 16'hFFFF; end
                2: begin req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000; end
                3: begin req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h000A; end
                5: begin req_write = 1'b1; req_addr = 16'h0000; req_wdata = 16'hDEAD; end
                6: req_valid = 1'b0;
                default: ;
            endcase
        end
        req_valid = 1'b0;
        check("hs write strobes", wr, 0);
        check("hs responses", nresp, 2);

        // Reset asserted in CAP of a byte store: abandoned, no write, no response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
        req_addr = 16'h000A; req_wdata = 16'h0011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw rd strobe", mem_read, 1);
        @(negedge clk);
        check("rmw cap strobe", mem_read | mem_write, 0);
        #1 rst = 1'b0;
        #1;
        check("midrst mem_read", mem_read, 0);
        check("midrst mem_write", mem_write, 0);
        check("midrst resp_valid", resp_valid, 0);
        check("midrst req_ready", req_ready, 1);
        check("midrst mem_addr", mem_addr, 0);
        wr = 0; nresp = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_write) wr++;
            if (resp_valid) nresp++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem_write) wr++;
            if (resp_valid) nresp++;
        end
        check("midrst writes", wr, 0);
        check("midrst responses", nresp, 0);
        check("midrst ready after", req_ready, 1);
        v = '{1'b0, 1'b0, 1'b0, 16'h000A, 16'h0000, 16'hF034, 1'b0, 16'h000A, 16'h0000};
        do_req(99, v);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store initiator that drives the byte-addressed data memory (16-bit big-endian word interface, 1-cycle registered read).
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Sequences the memory's read/write strobes.
- Performs byte loads with zero- or sign-extension.
- Performs byte stores as read-modify-write, because the memory only supports 16-bit writes.
- Returns one response per request.

Parameters:
ADDR_W, 16, address width (core and memory side)
DATA_W, 16, data width; fixed at 2 byte lanes
MEM_BYTES, 128, implemented memory size in bytes; sets the range check

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1=store, 0=load
req_byte  in  1  1=byte access, 0=word access
req_signed  in  1  byte load only: 1=sign-extend, 0=zero-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data; a byte store uses bits [7:0]
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_W  load result; 0 for stores and errors
resp_err  out  1  address out of range; qualified by resp_valid
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory word address (covers bytes A and A+1)
mem_wdata  out  DATA_W  memory write data {byte A, byte A+1}
mem_rdata  in  DATA_W  memory read data; valid in the cycle after mem_read is sampled

Behaviour:
- Reset (rst low, async):
  - state=IDLE.
  - req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_read=0, mem_write=0; mem_addr=0, mem_wdata=0.
  - Reset mid-operation abandons the request: no response, strobes drop immediately.
- States: IDLE, RD, CAP, WR, RESP.
- req_ready=1 only in IDLE. Acceptance = req_valid & req_ready at a clock edge, which latches all req_* fields.
- Range check at acceptance:
  - Word access is legal iff addr <= MEM_BYTES-2.
  - Byte access is legal iff addr <= MEM_BYTES-1.
  - Illegal → RESP with resp_err=1, resp_rdata=0; no memory strobe is ever asserted.
- Lane mapping for byte access:
  - addr < MEM_BYTES-1: word address = addr, high lane [15:8].
  - addr = MEM_BYTES-1: word address = addr-1, low lane [7:0].
- Word load: IDLE→RD→CAP→RESP→IDLE.
  - In RD, mem_read=1 and mem_addr=word address.
  - In CAP, mem_rdata is registered into resp_rdata.
  - resp_valid pulses in RESP, the 3rd cycle after acceptance.
- Byte load: same path as word load. resp_rdata = selected lane, extended to 16 bits per req_signed.
- Word store: IDLE→WR→RESP.
  - In WR, mem_write=1, mem_addr=addr, mem_wdata=req_wdata.
  - resp_valid pulses in the 2nd cycle after acceptance.
- Byte store: IDLE→RD→CAP→WR→RESP.
  - In CAP, the read word is merged with req_wdata[7:0] in the selected lane; the other lane is preserved.
  - WR writes the merged word to the same word address.
- mem_read and mem_write are never high together.
- Both strobes are low in IDLE, CAP and RESP. mem_addr and mem_wdata hold their last values when unused.
- RESP always returns to IDLE. The next request can be accepted at the edge ending RESP+1 (in IDLE); there are no back-to-back overlapping operations.
- resp_valid is high exactly one cycle per accepted request. There is no response backpressure.
- Address arithmetic: MEM_BYTES-1 and addr-1 are computed in ADDR_W bits. Upper address bits are not masked; out-of-range addresses are rejected by the check, never wrapped.

Decomposition:
- Package mem_lsu_pkg:
  - state enum (IDLE, RD, CAP, WR, RESP)
  - MEM_BYTES default
  - lane-select constants (LANE_HI, LANE_LO)
- One combinational sub-module, mem_lane_fmt:
  - inputs: word, lane, signed flag, store byte
  - outputs: extended load value, merged store word
  - used by the CAP state for both loads and stores

Test Plan:
1. Memory reset image is bytes 0..1 = AB,99, rest 00. Post-reset word load addr 0 → resp_rdata=0xAB99, err=0. resp_valid appears exactly 3 cycles after acceptance, with mem_read high for 1 cycle.
2. Word store addr 10 data 0x1234, then byte load addr 11 with signed=0 → 0x0034. Byte load addr 10 with signed=1 → 0x0012. Byte store 0xF0 at addr 10, then byte load addr 10 with signed=1 → 0xFFF0.
3. Byte store 0x5A at addr 20 over existing 0x1234 → word load 20 returns 0x5A34. The bench checks the sequence RD, CAP, WR (mem_write for 1 cycle, mem_addr=20, mem_wdata=0x5A34).
4. Top boundary:
   - Word store addr 126 data 0xBEEF → OK.
   - Byte store 0x77 at addr 127 → mem_addr=126, mem_wdata=0xBE77.
   - Byte load 127 → 0x0077.
   - Word access addr 127 → resp_err=1, rdata=0, no strobe.
   - Byte access addr 128 → err=1.
5. Handshake: hold req_valid high with changing fields during busy cycles. The bench checks req_ready=0 and the latched request is unchanged, so exactly one response per acceptance.
6. Assert rst low in CAP of a byte store → strobes low immediately, no resp_valid, no write. After release, req_ready=1 and the next word load returns a correct value.
